dcm_clkgen_programmer: RTL and testbench
========================================

Name: dcm_clkgen_programmer

Overview:
- Initiator for the DCM_CLKGEN dynamic M/D reprogramming port. It drives PROGEN and PROGDATA and monitors PROGDONE.
- Lets a running design retune a CLKGEN output frequency without reconfiguration. Examples: sweeping a serdes or sample clock, or switching between 125 and 250 MHz.
- Sits beside the DCM_CLKGEN wrapper. Its `clock` must also drive the DCM's PROGCLK (≤ 400 MHz), so all programming signals stay in one domain.

Parameters:
GAP_CYCLES, 2, idle cycles with prog_en=0 between LoadD/LoadM/GO commands (min 1)
DONE_TIMEOUT, 65535, max cycles to wait for progdone after GO before aborting (min 16, counter width = clog2(DONE_TIMEOUT+1))

Ports:
clock  in  1  single clock for the whole block; also feeds DCM PROGCLK
reset  in  1  asynchronous, active-low (0 = in reset)
start  in  1  request; sampled only in IDLE
multiply  in  9  requested M, legal 2..256
divide  in  9  requested D, legal 1..256
progdone  in  1  DCM PROGDONE, synchronous to clock
prog_en  out  1  to DCM PROGEN, registered
prog_data  out  1  to DCM PROGDATA, registered
busy  out  1  high from accepted start until return to IDLE
done  out  1  1-cycle pulse: programming completed
invalid  out  1  1-cycle pulse: start rejected, M/D out of range
timeout  out  1  1-cycle pulse: progdone never asserted within DONE_TIMEOUT

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - prog_en, prog_data, busy, done, invalid and timeout all 0.
  - Internal counters and latched M/D all 0.
- IDLE, start=1 on edge k:
  - If multiply∉[2,256] or divide∉[1,256]: invalid=1 during cycle k+1, stay IDLE, prog_en never asserted.
  - Otherwise latch m1=multiply-1 and d1=divide-1 (8 bits each), set busy=1 from k+1, enter LOAD_D. Later changes on multiply/divide are ignored.
- start while busy=1 is ignored; it is neither queued nor flagged.
- LOAD_D, exactly 10 cycles with prog_en=1:
  - prog_data sequence is 1, 0, then d1[0]..d1[7] (LSB first).
  - The first prog_en=1 cycle is k+1.
- GAP1, GAP_CYCLES cycles with prog_en=0 and prog_data=0.
- LOAD_M, 10 cycles with prog_en=1: prog_data sequence is 1, 1, then m1[0]..m1[7].
- GAP2, GAP_CYCLES cycles with prog_en=0.
- GO, 1 cycle: prog_en=1, prog_data=0.
- WAIT_DONE:
  - prog_en=0. The timeout counter clears on entry and increments every cycle.
  - progdone is ignored for the first 2 cycles; the DCM drops PROGDONE at the start of LoadD, so a stale high is not accepted.
  - From cycle 3 onward, progdone=1 → done=1 next cycle, busy=0, go to IDLE.
  - If the counter reaches DONE_TIMEOUT with no accepted progdone → timeout=1 next cycle, busy=0, IDLE. The caller must then reset the DCM.
  - If progdone and the terminal count coincide, done wins.
- Latency start→GO cycle = 1 + 10 + GAP_CYCLES + 10 + GAP_CYCLES. With defaults, GO is asserted at k+25.
- Outputs change only on rising clock; the DCM samples PROGEN/PROGDATA on the same rising PROGCLK one cycle later. This needs no extra synchronizer.
- Reset mid-operation:
  - Outputs drop to 0 asynchronously and no done/timeout is pulsed.
  - A partial LoadD/LoadM is abandoned.
  - The DCM must be reset alongside before its next use; this block does not drive the DCM's RST.
- done, invalid and timeout are mutually exclusive and never high for more than 1 cycle per request.

Test Plan:
1. M=10, D=4, GAP_CYCLES=2, bench DCM model raises progdone 40 cycles after GO:
   - prog_data during LOAD_D = 1,0,1,1,0,0,0,0,0,0; during LOAD_M = 1,1,1,0,0,1,0,0,0,0.
   - GO at k+25; done pulse exactly 1 cycle after progdone is sampled high; busy low the same cycle.
2. M=256, D=256 → data bits after the 2 command bits are all 1s for both loads. M=2, D=1 → M data bits 1,0,0,0,0,0,0,0; D data bits all 0. Both end with done.
3. start with M=1 (then, separately, D=0 and M=257) → invalid pulse at k+1; prog_en stays 0 for 50 cycles; busy never asserts.
4. DONE_TIMEOUT=100, progdone held 1 throughout: it is ignored for 2 cycles, then accepted → done. Separately, progdone held 0 → timeout pulse 101 cycles after the GO cycle, done never asserts.
5. start pulsed again at k+5 and k+20 during programming → the bit streams are identical to test 1 and exactly one done pulse is produced.
6. reset=0 asserted mid LOAD_M (k+17) → prog_en/prog_data/busy go 0 before the next edge. After release with no start, outputs stay idle. A fresh start then produces the full test-1 sequence.

Source files
------------

// File: rtl/dcm_clkgen_programmer_if.sv
// Request/status and DCM_CLKGEN programming-port signals for dcm_clkgen_programmer.
// master = requester plus DCM side, slave = the programmer block.
interface dcm_clkgen_programmer_if;
  logic       start;
  logic [8:0] multiply;
  logic [8:0] divide;
  logic       progdone;
  logic       prog_en;
  logic       prog_data;
  logic       busy;
  logic       done;
  logic       invalid;
  logic       timeout;

  modport master (
    output start, multiply, divide, progdone,
    input  prog_en, prog_data, busy, done, invalid, timeout
  );

  modport slave (
    input  start, multiply, divide, progdone,
    output prog_en, prog_data, busy, done, invalid, timeout
  );
endinterface

// File: rtl/dcm_clkgen_programmer.sv
// DCM_CLKGEN dynamic M/D programmer: LoadD, LoadM, GO, then wait for PROGDONE.
// i_clock must also drive the DCM PROGCLK so PROGEN/PROGDATA need no synchronizer.
module dcm_clkgen_programmer #(
  parameter int GAP_CYCLES   = 2,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  dcm_clkgen_programmer_if.slave  bus
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int CW = (TW > GW) ? TW : GW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOADD = 3'd1;
  localparam logic [2:0] S_GAP1  = 3'd2;
  localparam logic [2:0] S_LOADM = 3'd3;
  localparam logic [2:0] S_GAP2  = 3'd4;
  localparam logic [2:0] S_GO    = 3'd5;
  localparam logic [2:0] S_WAIT  = 3'd6;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_sh;
  logic [7:0]    r_m1;
  logic          r_en;
  logic          r_busy;
  logic          r_done;
  logic          r_invalid;
  logic          r_timeout;

  logic          w_bad;
  logic [7:0]    w_m1;
  logic [7:0]    w_d1;

  assign w_bad = (bus.multiply < 9'd2) ||
                 (bus.multiply > 9'd256) ||
                 (bus.divide == 9'd0) ||
                 (bus.divide > 9'd256);
  assign w_m1  = 8'(bus.multiply - 9'd1);
  assign w_d1  = 8'(bus.divide - 9'd1);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sh      <= '0;
      r_m1      <= '0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_invalid <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_invalid <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_bad) begin
              r_invalid <= 1'b1;
            end else begin
              r_m1    <= w_m1;
              r_sh    <= {w_d1, 2'b01};
              r_en    <= 1'b1;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_LOADD;
            end
          end
        end
        // r_sh[0] is the bit on PROGDATA; command bits go out first
        S_LOADD, S_LOADM: begin
          if (r_cnt == CW'(9)) begin
            r_en    <= 1'b0;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_state <= (r_state == S_LOADD) ? S_GAP1 : S_GAP2;
          end else begin
            r_sh  <= r_sh >> 1;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP1: begin
          if (r_cnt == CW'(GAP_CYCLES - 1)) begin
            r_en    <= 1'b1;
            r_sh    <= {r_m1, 2'b11};
            r_cnt   <= '0;
            r_state <= S_LOADM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP2: begin
          if (r_cnt == CW'(GAP_CYCLES - 1)) begin
            r_en    <= 1'b1;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_state <= S_GO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GO: begin
          r_en    <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        // the first two wait cycles may still see a stale PROGDONE
        S_WAIT: begin
          if (bus.progdone && (r_cnt >= CW'(2))) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == CW'(DONE_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_en    <= 1'b0;
          r_sh    <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.prog_en   = r_en;
  assign bus.prog_data = r_sh[0];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.invalid   = r_invalid;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_dcm_clkgen_programmer.sv
// Bench for dcm_clkgen_programmer: offset-based reference model checked every
// cycle, plus literal bit streams and pulse timings for directed requests.
`timescale 1ns/1ps
module tb_dcm_clkgen_programmer;

  localparam int GAP  = 2;
  localparam int DT   = 100;
  localparam int GO_T = 21 + 2 * GAP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcm_clkgen_programmer_if bus ();

  dcm_clkgen_programmer #(
    .GAP_CYCLES   (GAP),
    .DONE_TIMEOUT (DT)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int k      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic       s_rst;
  logic       s_start;
  logic       s_pd;
  logic [8:0] s_m;
  logic [8:0] s_d;

  always @(posedge clk) begin
    s_rst   <= rst_n;
    s_start <= bus.start;
    s_pd    <= bus.progdone;
    s_m     <= bus.multiply;
    s_d     <= bus.divide;
  end

  // expected PROGDATA for offset t after the accepted start edge
  function automatic logic exp_bit(int t, logic [7:0] d1, logic [7:0] m1);
    if (t == 1) return 1'b1;
    if (t == 2) return 1'b0;
    if (t >= 3 && t <= 10) return d1[t-3];
    if (t == 11 + GAP || t == 12 + GAP) return 1'b1;
    if (t >= 13 + GAP && t <= 20 + GAP) return m1[t-13-GAP];
    return 1'b0;
  endfunction

  bit         m_act = 0;
  int         m_t   = 0;
  logic [7:0] m_m1  = '0;
  logic [7:0] m_d1  = '0;

  always @(negedge clk) begin
    logic [5:0] e;
    logic [5:0] g;
    bit pd;
    bit pt;
    bit pi;
    int j;
    pd = 0;
    pt = 0;
    pi = 0;
    if (!rst_n) begin
      m_act = 0;
    end else if (s_rst === 1'b1) begin
      if (m_act) begin
        j = m_t - GO_T;
        if (j >= 3 && s_pd) begin
          pd = 1;
          m_act = 0;
        end else if (j == DT) begin
          pt = 1;
          m_act = 0;
        end else begin
          m_t++;
        end
      end else if (s_start) begin
        if (s_m < 2 || s_m > 256 || s_d < 1 || s_d > 256) begin
          pi = 1;
        end else begin
          m_act = 1;
          m_t   = 1;
          m_m1  = 8'(s_m - 9'd1);
          m_d1  = 8'(s_d - 9'd1);
        end
      end
    end
    e = '0;
    if (m_act) begin
      e[5] = (m_t <= 10) ||
             (m_t >= 11 + GAP && m_t <= 20 + GAP) ||
             (m_t == GO_T);
      e[4] = e[5] && exp_bit(m_t, m_d1, m_m1);
      e[3] = 1'b1;
    end
    e[2] = pd;
    e[1] = pi;
    e[0] = pt;
    g = {bus.prog_en, bus.prog_data, bus.busy,
         bus.done, bus.invalid, bus.timeout};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL cycle %0d outputs{en,data,busy,done,inv,tmo} got %b want %b",
               cyc, g, e);
    end
  end

  logic q[$];
  int   en_cyc[$];
  int   n_done, done_cyc, n_inv, inv_cyc, n_tmo, tmo_cyc, n_busy;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.prog_en) begin
        q.push_back(bus.prog_data);
        en_cyc.push_back(cyc);
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.invalid) begin
        n_inv++;
        inv_cyc = cyc;
      end
      if (bus.timeout) begin
        n_tmo++;
        tmo_cyc = cyc;
      end
      if (bus.busy) n_busy++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    q.delete();
    en_cyc.delete();
    n_done = 0; done_cyc = -1;
    n_inv  = 0; inv_cyc  = -1;
    n_tmo  = 0; tmo_cyc  = -1;
    n_busy = 0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int stream();
    int v;
    v = 0;
    for (int i = 0; i < q.size() && i < 21; i++) v = (v << 1) | int'(q[i]);
    return v;
  endfunction

  function automatic int off(int c);
    return c - k + 1;
  endfunction

  task automatic start_req(input logic [8:0] m, input logic [8:0] d);
    clr();
    bus.start    = 1'b1;
    bus.multiply = m;
    bus.divide   = d;
    tick();
    k = cyc;
    bus.start = 1'b0;
  endtask

  task automatic run_ok(input logic [8:0] m, input logic [8:0] d, input int pdg);
    start_req(m, d);
    repeat (GO_T + pdg - 1) tick();
    bus.progdone = 1'b1;
    tick();
    bus.progdone = 1'b0;
    repeat (4) tick();
  endtask

  task automatic chk_t1(input string tag);
    chk({tag, " bits"}, stream(), 21'b1011000000_1110010000_0);
    chk({tag, " en_len"}, q.size(), 21);
    chk({tag, " go_t"}, (en_cyc.size() == 21) ? off(en_cyc[20]) : -1, 25);
    chk({tag, " done_t"}, off(done_cyc), 66);
    chk({tag, " n_done"}, n_done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $finish;
  end

  initial begin
    bus.start    = 1'b0;
    bus.multiply = '0;
    bus.divide   = '0;
    bus.progdone = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs",
        int'({bus.prog_en, bus.prog_data, bus.busy,
              bus.done, bus.invalid, bus.timeout}), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    run_ok(9'd10, 9'd4, 40);
    chk_t1("t1");

    run_ok(9'd256, 9'd256, 7);
    chk("t2max bits", stream(), 21'b1011111111_1111111111_0);
    chk("t2max n_done", n_done, 1);
    run_ok(9'd2, 9'd1, 3);
    chk("t2min bits", stream(), 21'b1000000000_1110000000_0);
    chk("t2min done_t", off(done_cyc), GO_T + 4);

    start_req(9'd1, 9'd4);
    repeat (50) tick();
    chk("t3 m1 inv_t", off(inv_cyc), 1);
    chk("t3 m1 en", q.size() + n_busy, 0);
    start_req(9'd10, 9'd0);
    repeat (50) tick();
    chk("t3 d0 inv_t", off(inv_cyc), 1);
    chk("t3 d0 en", q.size() + n_busy, 0);
    start_req(9'd257, 9'd4);
    repeat (50) tick();
    chk("t3 m257 n_inv", n_inv, 1);
    chk("t3 m257 en", q.size() + n_busy, 0);

    bus.progdone = 1'b1;
    start_req(9'd10, 9'd4);
    repeat (GO_T + 10) tick();
    bus.progdone = 1'b0;
    chk("t4 held done_t", off(done_cyc), 29);
    chk("t4 held n_done", n_done, 1);
    start_req(9'd10, 9'd4);
    repeat (GO_T + DT + 5) tick();
    chk("t4 tmo_t", off(tmo_cyc), 126);
    chk("t4 tmo n", n_tmo, 1);
    chk("t4 tmo n_done", n_done, 0);

    start_req(9'd10, 9'd4);
    repeat (4) tick();
    bus.start = 1'b1; bus.multiply = 9'd3; bus.divide = 9'd3;
    tick();
    bus.start = 1'b0;
    repeat (14) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (44) tick();
    bus.progdone = 1'b1;
    tick();
    bus.progdone = 1'b0;
    repeat (4) tick();
    chk_t1("t5");

    start_req(9'd10, 9'd4);
    repeat (16) tick();
    chk("t6 pre en", int'(bus.prog_en), 1);
    rst_n = 1'b0;
    #2;
    chk("t6 async",
        int'({bus.prog_en, bus.prog_data, bus.busy}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    repeat (10) tick();
    chk("t6 idle", q.size() + n_busy + n_done + n_tmo, 0);
    run_ok(9'd10, 9'd4, 40);
    chk_t1("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
